mips_alu: RTL and testbench

// - 32-bit integer ALU for the MIPS execute stage; 16 operations (arith, logic, compare, shift, move, LUI).
// - Result and zero flag are registered: one clock of latency; the EX/MEM path consumes them directly.
// - Operand muxing (register/immediate/shamt) is done upstream; this block only computes.

---
 rtl/mips_alu_if.sv | 21 ++
 rtl/mips_alu.sv | 84 ++++++++
 tb/tb_mips_alu.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mips_alu_if.sv
// rtl/mips_alu_if.sv - operand/result bundle for mips_alu; overflow present only with ALU_OVF_EN
interface mips_alu_if;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_out;
  logic        zero;
`ifdef ALU_OVF_EN
  logic        overflow;

  modport master (output alu_a, output alu_b, output alu_op,
                  input alu_out, input zero, input overflow);
  modport slave  (input alu_a, input alu_b, input alu_op,
                  output alu_out, output zero, output overflow);
`else
  modport master (output alu_a, output alu_b, output alu_op,
                  input alu_out, input zero);
  modport slave  (input alu_a, input alu_b, input alu_op,
                  output alu_out, output zero);
`endif
endinterface

// File: rtl/mips_alu.sv
// rtl/mips_alu.sv - registered 32-bit MIPS execute-stage ALU; ALU_OVF_EN adds signed overflow flag
module mips_alu (
  input logic      clk,
  input logic      rst,
  mips_alu_if.slave bus
);

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_NOR  = 5'd6;
  localparam logic [4:0] OP_ADDU = 5'd7;
  localparam logic [4:0] OP_SUBU = 5'd8;
  localparam logic [4:0] OP_SLT  = 5'd9;
  localparam logic [4:0] OP_SLTU = 5'd10;
  localparam logic [4:0] OP_SLL  = 5'd11;
  localparam logic [4:0] OP_SRL  = 5'd12;
  localparam logic [4:0] OP_SRA  = 5'd13;
  localparam logic [4:0] OP_MOV  = 5'd14;
  localparam logic [4:0] OP_LUI  = 5'd15;

  logic [31:0] sum;
  logic [31:0] diff;
  logic [4:0]  shamt;
  logic [31:0] result;

  assign sum   = bus.alu_a + bus.alu_b;
  assign diff  = bus.alu_a - bus.alu_b;
  assign shamt = bus.alu_a[4:0];

  always_comb begin
    result = 32'h0;
    case (bus.alu_op)
      OP_NOP:          result = 32'h0;
      OP_ADD, OP_ADDU: result = sum;
      OP_SUB, OP_SUBU: result = diff;
      OP_AND:          result = bus.alu_a & bus.alu_b;
      OP_OR:           result = bus.alu_a | bus.alu_b;
      OP_XOR:          result = bus.alu_a ^ bus.alu_b;
      OP_NOR:          result = ~(bus.alu_a | bus.alu_b);
      OP_SLT:          result = {31'b0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      OP_SLTU:         result = {31'b0, bus.alu_a < bus.alu_b};
      OP_SLL:          result = bus.alu_b << shamt;
      OP_SRL:          result = bus.alu_b >> shamt;
      OP_SRA:          result = $signed(bus.alu_b) >>> shamt;
      OP_MOV:          result = bus.alu_a;
      OP_LUI:          result = {bus.alu_b[15:0], 16'h0};
      default:         result = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_out <= 32'h0;
      bus.zero    <= 1'b1;
    end else begin
      bus.alu_out <= result;
      bus.zero    <= (result == 32'h0);
    end
  end

`ifdef ALU_OVF_EN
  // Only the trapping forms flag; ADDU/SUBU share the adder but never overflow.
  logic ovf_next;

  always_comb begin
    ovf_next = 1'b0;
    case (bus.alu_op)
      OP_ADD:  ovf_next = (bus.alu_a[31] == bus.alu_b[31]) && (sum[31] != bus.alu_a[31]);
      OP_SUB:  ovf_next = (bus.alu_a[31] != bus.alu_b[31]) && (diff[31] != bus.alu_a[31]);
      default: ovf_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.overflow <= 1'b0;
    else     bus.overflow <= ovf_next;
  end
`endif

endmodule

// File: tb/tb_mips_alu.sv
// tb/tb_mips_alu.sv - self-checking bench for mips_alu (model + directed vectors)
module tb_mips_alu;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   started;

  mips_alu_if bus ();
  mips_alu dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sb;
    longint sa, sbl;
    sb  = b;
    sa  = longint'($signed(a));
    sbl = longint'($signed(b));
    case (op)
      1, 7:    return a + b;
      2, 8:    return a - b;
      3:       return a & b;
      4:       return a | b;
      5:       return a ^ b;
      6:       return ~(a | b);
      9:       return (sa < sbl) ? 32'd1 : 32'd0;
      10:      return ({32'b0, a} < {32'b0, b}) ? 32'd1 : 32'd0;
      11:      return b << a[4:0];
      12:      return b >> a[4:0];
      13:      return 32'(sb >>> a[4:0]);
      14:      return a;
      15:      return b * 32'h10000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic model_ovf(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint r;
    if (op == 5'd1)      r = longint'($signed(a)) + longint'($signed(b));
    else if (op == 5'd2) r = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  logic [31:0] m_out;
  logic        m_zero;
  logic        m_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out  <= 32'h0;
      m_zero <= 1'b1;
      m_ovf  <= 1'b0;
    end else begin
      m_out  <= model_res(bus.alu_op, bus.alu_a, bus.alu_b);
      m_zero <= (model_res(bus.alu_op, bus.alu_a, bus.alu_b) == 32'h0);
      m_ovf  <= model_ovf(bus.alu_op, bus.alu_a, bus.alu_b);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (bus.alu_out !== m_out || bus.zero !== m_zero) begin
        errors++;
        $display("FAIL model_cmp t=%0t: alu_out=%h zero=%b, required alu_out=%h zero=%b",
                 $time, bus.alu_out, bus.zero, m_out, m_zero);
      end
`ifdef ALU_OVF_EN
      checks++;
      if (bus.overflow !== m_ovf) begin
        errors++;
        $display("FAIL model_ovf t=%0t: overflow=%b required %b", $time, bus.overflow, m_ovf);
      end
`endif
    end
  end

  task automatic check_out(input string name, input logic [31:0] exp_out, input logic exp_zero);
    checks++;
    if (bus.alu_out !== exp_out || bus.zero !== exp_zero) begin
      errors++;
      $display("FAIL %s: alu_out=%h zero=%b, required alu_out=%h zero=%b",
               name, bus.alu_out, bus.zero, exp_out, exp_zero);
    end
  endtask

  // Called just after a falling edge; checks the result one rising edge later.
  task automatic run(input string name, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] r, input logic ovf);
    bus.alu_op = op;
    bus.alu_a  = a;
    bus.alu_b  = b;
    @(posedge clk);
    #1;
    check_out(name, r, r == 32'h0);
`ifdef ALU_OVF_EN
    checks++;
    if (bus.overflow !== ovf) begin
      errors++;
      $display("FAIL %s_ovf: overflow=%b required %b", name, bus.overflow, ovf);
    end
`else
    if (ovf) begin end
`endif
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    started = 1'b0;
    rst = 1'b1;
    bus.alu_op = 5'd1;
    bus.alu_a  = 32'd5;
    bus.alu_b  = 32'd6;
    #3;
    check_out("reset_no_edge", 32'h0, 1'b1);
    started = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_out("first_after_release", 32'd11, 1'b0);
    @(negedge clk);

    run("slt_2_3",    5'd9,  32'd2,        32'd3,        32'd1, 1'b0);
    run("slt_3_2",    5'd9,  32'd3,        32'd2,        32'd0, 1'b0);
    run("slt_m2_m3",  5'd9,  32'hFFFFFFFE, 32'hFFFFFFFD, 32'd0, 1'b0);
    run("slt_m3_m2",  5'd9,  32'hFFFFFFFD, 32'hFFFFFFFE, 32'd1, 1'b0);
    run("sltu_2_3",   5'd10, 32'd2,        32'd3,        32'd1, 1'b0);
    run("sltu_3_2",   5'd10, 32'd3,        32'd2,        32'd0, 1'b0);
    run("sltu_fe_fd", 5'd10, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd0, 1'b0);
    run("sltu_fd_fe", 5'd10, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd1, 1'b0);
    run("sltu_2_fd",  5'd10, 32'd2,        32'hFFFFFFFD, 32'd1, 1'b0);
    run("nop",        5'd0,  32'h0,        32'h00CCA955, 32'h0, 1'b0);
    run("op20",       5'd20, 32'h12345678, 32'h9ABCDEF0, 32'h0, 1'b0);
    run("subu_wrap",  5'd8,  32'h80000000, 32'hFFFFFFFF, 32'h80000001, 1'b0);
    run("sub_same",   5'd2,  32'h80000000, 32'hFFFFFFFF, 32'h80000001, 1'b0);
    run("add_ovf",    5'd1,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1);
    run("addu_noovf", 5'd7,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0);
    run("sub_ovf",    5'd2,  32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1);
    run("add_carry",  5'd1,  32'hFFFFFFFF, 32'h1,        32'h0, 1'b0);
    run("sra",        5'd13, 32'd4,        32'h80000000, 32'hF8000000, 1'b0);
    run("srl",        5'd12, 32'd4,        32'h80000000, 32'h08000000, 1'b0);
    run("sll_31",     5'd11, 32'd31,       32'h1,        32'h80000000, 1'b0);
    run("sll_hi_ign", 5'd11, 32'hFFFFFFE0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);
    run("sra_0",      5'd13, 32'h0,        32'h80000001, 32'h80000001, 1'b0);
    run("lui",        5'd15, 32'hFFFFFFFF, 32'h1234ABCD, 32'hABCD0000, 1'b0);
    run("and",        5'd3,  32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 1'b0);
    run("or",         5'd4,  32'hF0F0FF00, 32'h0FF0F0F0, 32'hFFF0FFF0, 1'b0);
    run("xor",        5'd5,  32'hF0F0FF00, 32'h0FF0F0F0, 32'hFF000FF0, 1'b0);
    run("nor",        5'd6,  32'hF0F0FF00, 32'h0FF0F0F0, 32'h000F000F, 1'b0);
    run("mov",        5'd14, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0);

    // Mid-stream reset clears outputs without waiting for an edge.
    bus.alu_op = 5'd14;
    bus.alu_a  = 32'hCAFEF00D;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_out("reset_midstream", 32'h0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    run("after_reset", 5'd1, 32'd100, 32'd23, 32'd123, 1'b0);

    for (int i = 0; i < 40; i++) begin
      bus.alu_op = 5'($urandom_range(0, 31));
      bus.alu_a  = $urandom;
      bus.alu_b  = (i % 4 == 0) ? bus.alu_a : $urandom;
      @(negedge clk);
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
